// File: rtl/randomized_lfsr_gen_pkg.sv
// Shared types and LFSR tap constants for the randomized_lfsr_gen random-word generator.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_STIR,
    ST_VALID,
    ST_FAIL
  } state_t;

  // Masks have bit (n-1) set for each 1-based tap position n.
  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;  // {8,6,5,4}
  localparam logic [31:0] TAPS_16 = 32'h0000_D008;  // {16,15,13,4}
  localparam logic [31:0] TAPS_24 = 32'h00E1_0000;  // {24,23,22,17}
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // {32,22,2,1}

  function automatic bit width_legal(input int unsigned w);
    return (w == 8) || (w == 16) || (w == 24) || (w == 32);
  endfunction

  function automatic logic [31:0] tap_mask(input int unsigned w);
    logic [31:0] m;
    m = '0;
    case (w)
      8:       m = TAPS_8;
      16:      m = TAPS_16;
      24:      m = TAPS_24;
      32:      m = TAPS_32;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/randomized_lfsr_gen_if.sv
// Output word handshake: the generator is the master, the consumer the slave.
interface randomized_lfsr_gen_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (output out_valid, output out, input out_ready);
  modport slave  (input out_valid, input out, output out_ready);
endinterface

// File: rtl/trng_health_monitor.sv
// Repetition-count health test: trips when the entropy bit repeats REP_LIMIT times in a row.
module trng_health_monitor #(
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic clear,
  input  logic entropy_bit,
  output logic trip,
  output logic fail
);

  logic [7:0] rep_cnt;
  logic       last_bit;

  assign trip = (rep_cnt == 8'(REP_LIMIT));

  // rep_cnt is the current run length; a changed sample restarts the run at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
      fail     <= 1'b0;
    end else begin
      if (trip) fail <= 1'b1;
      if (clear) begin
        rep_cnt <= '0;
      end else if (sample_en) begin
        last_bit <= entropy_bit;
        if (rep_cnt == '0 || entropy_bit != last_bit) rep_cnt <= 8'd1;
        else if (!trip) rep_cnt <= rep_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/randomized_lfsr_gen.sv
// Ring-oscillator entropy mixed into a Fibonacci LFSR, with warm-up/stir FSM and valid/ready output.
// Optional repetition health test enabled by defining RANDOMIZED_LFSR_HEALTH_EN.

// Flop-based twisted ring standing in for the free-running inverter ring macro.
module ringoscillator #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  output logic osc
);
  logic [STAGES-1:0] ring;

  always_ff @(posedge clk) begin
    if (reset) ring <= '0;
    else       ring <= {ring[STAGES-2:0], ~ring[STAGES-1]};
  end

  assign osc = ring[STAGES-1];
endmodule

module randomized_lfsr_gen
  import trng_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned OSC_COUNT     = 4,
  parameter int unsigned WARMUP_CYCLES = 256,
  parameter int unsigned REP_LIMIT     = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  enable,
  randomized_lfsr_gen_if.master bus,
  output logic                  health_fail
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("randomized_lfsr_gen: WIDTH must be 8, 16, 24 or 32");
  end
  if (OSC_COUNT < 2 || OSC_COUNT > 8) begin : g_bad_osc
    $error("randomized_lfsr_gen: OSC_COUNT must be 2..8");
  end
  if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep
    $error("randomized_lfsr_gen: REP_LIMIT must be 2..255");
  end

  localparam logic [31:0]      TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
  localparam int unsigned      CNT_MAX   = (WARMUP_CYCLES > WIDTH) ? WARMUP_CYCLES : WIDTH;
  localparam int unsigned      CW        = $clog2(CNT_MAX + 1);

  logic [OSC_COUNT-1:0] osc;
  logic [1:0]           sync_q;
  logic                 entropy_bit;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 cnt_last;
  logic [WIDTH-1:0]     lfsr_q, lfsr_next, out_q;
  logic                 fb, shift, load, trip;

  for (genvar i = 0; i < OSC_COUNT; i++) begin : g_osc
    ringoscillator #(.STAGES(3 + 2 * i)) u_osc (
      .clk   (CLK),
      .reset (reset),
      .osc   (osc[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], ^osc};
  end

  assign entropy_bit = sync_q[1];

  always_comb begin
    fb = (^(lfsr_q & TAPS)) ^ entropy_bit;
    if (lfsr_q == '0) fb = 1'b1;
    lfsr_next = {lfsr_q[WIDTH-2:0], fb};
  end

  always_ff @(posedge CLK) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_last = (state_q == ST_WARMUP) ? (cnt_q == CW'(WARMUP_CYCLES - 1))
                                      : (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_WARMUP;
      ST_WARMUP: if (cnt_last) state_d = ST_STIR;
      ST_STIR:   if (cnt_last) state_d = ST_VALID;
      ST_VALID:  if (bus.out_ready) state_d = ST_STIR;
      ST_FAIL:   state_d = ST_FAIL;
      default:   state_d = ST_IDLE;
    endcase
    if (!enable && state_q != ST_FAIL) state_d = ST_IDLE;
    if (trip) state_d = ST_FAIL;
    shift = (state_q == ST_WARMUP) || (state_q == ST_STIR);
    load  = (state_q == ST_STIR) && (state_d == ST_VALID);
  end

  // The word is taken from the post-shift value, so out equals the LFSR while VALID.
  always_ff @(posedge CLK) begin
    if (reset) begin
      lfsr_q <= WIDTH'(1);
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      if (shift) lfsr_q <= lfsr_next;
      if (state_d != state_q) cnt_q <= '0;
      else if (shift)         cnt_q <= cnt_q + CW'(1);
      if (load) out_q <= lfsr_next;
    end
  end

  assign bus.out_valid = (state_q == ST_VALID);
  assign bus.out       = out_q;

`ifdef RANDOMIZED_LFSR_HEALTH_EN
  trng_health_monitor #(.REP_LIMIT(REP_LIMIT)) u_health (
    .clk         (CLK),
    .reset       (reset),
    .sample_en   (shift),
    .clear       (state_q == ST_IDLE),
    .entropy_bit (entropy_bit),
    .trip        (trip),
    .fail        (health_fail)
  );
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_randomized_lfsr_gen.sv
// Directed self-checking bench for randomized_lfsr_gen (WIDTH=16, WARMUP_CYCLES=256, REP_LIMIT=32).
module tb_randomized_lfsr_gen;
  import trng_pkg::*;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned WARMUP = 256;

  logic        clk = 1'b0;
  logic        reset, enable, health_fail;
  logic        ent;
  bit          ent_mode;
  logic [31:0] pat = 32'hA5C3_96E1;
  int unsigned pidx;
  logic [15:0] model;
  int          total, bad;

  randomized_lfsr_gen_if #(.WIDTH(WIDTH)) bus ();

  randomized_lfsr_gen #(
    .WIDTH(WIDTH), .OSC_COUNT(4), .WARMUP_CYCLES(WARMUP), .REP_LIMIT(32)
  ) dut (
    .CLK(clk), .reset(reset), .enable(enable), .bus(bus), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic e);
    logic f;
    f = s[15] ^ s[14] ^ s[12] ^ s[3] ^ e;
    if (s == 16'h0000) f = 1'b1;
    return {s[14:0], f};
  endfunction

  task automatic set_ent(input logic b);
    ent = b;
    force dut.entropy_bit = ent;
  endtask

  // One clock; sh tells the model whether the DUT shifts on this edge.
  task automatic tick(input bit sh);
    if (ent_mode) begin
      set_ent(pat[pidx]);
      pidx = (pidx + 1) % 32;
    end
    if (sh) model = mstep(model, ent);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; bus.out_ready = 1'b0;
    ent_mode = 1'b1; pidx = 0; model = 16'h0001;
    repeat (3) tick(0);
    reset = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%0h want=0", bus.out); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health got=%0b want=0", health_fail); end
    for (int i = 0; i < 1000; i++) begin
      tick(0);
      total++;
      if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || health_fail !== 1'b0) begin
        bad++; $display("FAIL idle_outputs cycle=%0d got=%0b/%0h/%0b want=0/0/0", i, bus.out_valid, bus.out, health_fail);
      end
    end
    total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL idle_lfsr_hold got=%0h want=1", dut.lfsr_q); end
  endtask

  task automatic test_warmup;
    ent_mode = 1'b0; set_ent(1'b0);
    bus.out_ready = 1'b1; enable = 1'b1;
    tick(0);
    total++; if (dut.state_q !== ST_WARMUP) begin bad++; $display("FAIL enter_warmup got=%0d want=%0d", dut.state_q, ST_WARMUP); end
    repeat (4) tick(1);
    // 0001 -> 0002 -> 0004 -> 0008 -> 0011 with zero entropy
    total++; if (dut.lfsr_q !== 16'h0011) begin bad++; $display("FAIL warmup_shift4 got=%0h want=0011", dut.lfsr_q); end
    ent_mode = 1'b1;
    for (int i = 0; i < 267; i++) begin
      tick(1);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL warmup_early_valid step=%0d got=1 want=0", i); end
    end
    tick(1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out !== model) begin bad++; $display("FAIL first_word got=%0h want=%0h", bus.out, model); end
    for (int w = 0; w < 3; w++) begin
      tick(0);
      for (int i = 0; i < 16; i++) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_gap word=%0d step=%0d got=1 want=0", w, i); end
        tick(1);
      end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid word=%0d got=%0b want=1", w, bus.out_valid); end
      total++; if (bus.out !== model) begin bad++; $display("FAIL stream_word word=%0d got=%0h want=%0h", w, bus.out, model); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 50; i++) begin
      tick(0);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out !== model) begin
        bad++; $display("FAIL bp_hold cycle=%0d got=%0b/%0h want=1/%0h", i, bus.out_valid, bus.out, model);
      end
    end
    bus.out_ready = 1'b1;
    tick(0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_gap step=%0d got=1 want=0", i); end
      tick(1);
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out !== model) begin bad++; $display("FAIL bp_next_word got=%0h want=%0h", bus.out, model); end
  endtask

  task automatic test_abort;
    bus.out_ready = 1'b1;
    tick(0);
    bus.out_ready = 1'b0;
    repeat (3) tick(1);
    enable = 1'b0;
    tick(1);
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL abort_idle got=%0d want=%0d", dut.state_q, ST_IDLE); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b want=0", bus.out_valid); end
    repeat (5) tick(0);
    total++; if (dut.lfsr_q !== model) begin bad++; $display("FAIL abort_lfsr_hold got=%0h want=%0h", dut.lfsr_q, model); end
    enable = 1'b1;
    tick(0);
    for (int i = 0; i < 271; i++) begin
      tick(1);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rewarm_early_valid step=%0d got=1 want=0", i); end
    end
    tick(1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rewarm_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out !== model) begin bad++; $display("FAIL rewarm_word got=%0h want=%0h", bus.out, model); end
    reset = 1'b1; enable = 1'b0;
    tick(0);
    reset = 1'b0; model = 16'h0001;
    total++; if (bus.out !== 16'h0000) begin bad++; $display("FAIL midreset_out got=%0h want=0", bus.out); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%0b want=0", bus.out_valid); end
    total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL midreset_lfsr got=%0h want=1", dut.lfsr_q); end
  endtask

  task automatic test_zero_lockup;
    ent_mode = 1'b0;
    enable = 1'b1;
    tick(0);
    // Entropy cancels the taps so sixteen zeros are shifted in.
    for (int i = 0; i < 16; i++) begin
      set_ent(model[15] ^ model[14] ^ model[12] ^ model[3]);
      tick(1);
    end
    total++; if (dut.lfsr_q !== 16'h0000) begin bad++; $display("FAIL zero_reached got=%0h want=0", dut.lfsr_q); end
    set_ent(1'b0);
    tick(1);
    total++; if (dut.lfsr_q !== 16'h0001) begin bad++; $display("FAIL zero_escape got=%0h want=0001", dut.lfsr_q); end
    tick(1);
    total++; if (dut.lfsr_q !== 16'h0002) begin bad++; $display("FAIL zero_after got=%0h want=0002", dut.lfsr_q); end
    reset = 1'b1; enable = 1'b0;
    tick(0);
    reset = 1'b0; model = 16'h0001;
  endtask

  task automatic test_health;
    ent_mode = 1'b0; set_ent(1'b0);
`ifdef RANDOMIZED_LFSR_HEALTH_EN
    enable = 1'b1;
    tick(0);
    repeat (32) tick(1);
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_early got=%0b want=0", health_fail); end
    total++; if (dut.state_q !== ST_WARMUP) begin bad++; $display("FAIL health_pre_state got=%0d want=%0d", dut.state_q, ST_WARMUP); end
    tick(1);
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL health_trip got=%0b want=1", health_fail); end
    total++; if (dut.state_q !== ST_FAIL) begin bad++; $display("FAIL health_state got=%0d want=%0d", dut.state_q, ST_FAIL); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL health_valid got=%0b want=0", bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      enable = ~enable;
      tick(0);
      total++;
      if (dut.state_q !== ST_FAIL || health_fail !== 1'b1) begin
        bad++; $display("FAIL health_sticky step=%0d got=%0d/%0b want=%0d/1", i, dut.state_q, health_fail, ST_FAIL);
      end
    end
    reset = 1'b1; enable = 1'b0;
    tick(0);
    reset = 1'b0;
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_reset got=%0b want=0", health_fail); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL health_reset_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
`else
    bus.out_ready = 1'b1; enable = 1'b1;
    tick(0);
    for (int i = 0; i < 271; i++) begin
      tick(1);
      total++;
      if (health_fail !== 1'b0 || bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL nohealth_warm step=%0d got=%0b/%0b want=0/0", i, health_fail, bus.out_valid);
      end
    end
    tick(1);
    for (int w = 0; w < 3; w++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL nohealth_valid word=%0d got=%0b want=1", w, bus.out_valid); end
      total++; if (bus.out !== model) begin bad++; $display("FAIL nohealth_word word=%0d got=%0h want=%0h", w, bus.out, model); end
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL nohealth_flag word=%0d got=%0b want=0", w, health_fail); end
      tick(0);
      repeat (16) tick(1);
    end
    enable = 1'b0; bus.out_ready = 1'b0;
    tick(0);
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; enable = 1'b0; bus.out_ready = 1'b0;
    model = 16'h0001; pidx = 0; ent_mode = 1'b0;
    set_ent(1'b0);
    test_reset();
    test_warmup();
    test_backpressure();
    test_abort();
    test_zero_lockup();
    test_health();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
